slot_dispatch_table: RTL and testbench
======================================

Name: slot_dispatch_table

Overview:
Parametrised slot table with a built-in sequencer. It holds 2^INDEX_WIDTH DMA descriptor slots (src/dst address and size, status, profile). On start, it walks the slots in index order and issues each READY slot over a valid/ready dispatch handshake. It then waits for completion, counts busy cycles into the slot's profile field, and marks the slot DONE. It sits between the host register interface and the DMA/reconfiguration engine.

Parameters:
INDEX_WIDTH, 2, slot count = 2^INDEX_WIDTH (N)
SRC_ADDR_WIDTH, 32, source address width
SRC_SIZE_WIDTH, 26, source size width
DST_ADDR_WIDTH, 32, destination address width
DST_SIZE_WIDTH, 26, destination size width
PROFILE_WIDTH, 32, per-slot busy-cycle counter width (saturating)

Ports:
clk  in  1  clock; sole clock domain
reset  in  1  synchronous, active-high reset
cfg_index  in  INDEX_WIDTH  slot selected for config write
cfg_src_addr / cfg_src_size / cfg_des_addr / cfg_des_size  in  field widths  write data
cfg_status  in  2  write data for status
set_src_addr / set_src_size / set_des_addr / set_des_size / set_status  in  1 each  per-field write strobes
rd_index  in  INDEX_WIDTH  read-port slot select
rd_src_addr / rd_src_size / rd_des_addr / rd_des_size / rd_status / rd_profile  out  field widths  combinational read of slot rd_index
start  in  1  pulse: begin one dispatch pass
busy  out  1  FSM not IDLE
seq_done  out  1  one-cycle pulse at end of pass
dsp_valid  out  1  descriptor offered
dsp_ready  in  1  engine accepts descriptor
dsp_index / dsp_src_addr / dsp_src_size / dsp_des_addr / dsp_des_size  out  field widths  registered descriptor
cmp_valid  in  1  one-cycle pulse: active descriptor complete

Behaviour:
- Status encoding: 0 EMPTY, 1 READY, 2 BUSY, 3 DONE.
- Reset: every slot field and profile is 0 (status EMPTY). ptr=0, FSM IDLE. busy, seq_done, dsp_valid and all dsp_* outputs are 0.
- Reset mid-operation has the same effect and takes priority over all other inputs. The in-flight descriptor is abandoned.
- FSM states: IDLE, SCAN, ISSUE, WAIT.
- IDLE: start=1 sets ptr=0 and moves to SCAN. start in any other state is ignored.
- SCAN: examines one slot per cycle.
  - If status[ptr]==READY: latch the slot fields into dsp_*, set dsp_valid=1, go to ISSUE.
  - Otherwise, if ptr==N-1: go to IDLE with seq_done=1 for one cycle.
  - Otherwise: ptr++.
- ISSUE: dsp_valid and dsp_* are held stable until dsp_ready=1. On the handshake cycle:
  - dsp_valid goes to 0.
  - status[ptr] becomes BUSY and profile[ptr] becomes 0.
  - FSM goes to WAIT.
- WAIT: profile[ptr] increments every cycle, including the cycle cmp_valid is high, and saturates at all-ones. On cmp_valid:
  - status[ptr] becomes DONE.
  - If ptr==N-1: go to IDLE and pulse seq_done. Otherwise: ptr++ and go to SCAN.
- cmp_valid outside WAIT is ignored.
- Latency: with start at cycle t and slot 0 READY, dsp_valid is high at t+2. With no READY slots, seq_done is high at t+N+1.
- Config writes are applied on the clock edge to slot cfg_index. Multiple strobes in one cycle all apply.
- Config writes to slot ptr while FSM is in ISSUE or WAIT are dropped, all fields including status. The FSM owns that slot. Writes to other slots are always accepted, including marking a slot with index greater than ptr READY mid-pass, which is then dispatched in the same pass.
- Profile is never host-writable. Each pass dispatches a slot at most once, and DONE slots are not re-dispatched until the host rewrites their status to READY.
- The read port is combinational; it reflects a write on the cycle after the write edge.

Decomposition:
- Package slot_dispatch_pkg holds:
  - status constants ST_EMPTY/ST_READY/ST_BUSY/ST_DONE (2 bits);
  - FSM state encoding S_IDLE/S_SCAN/S_ISSUE/S_WAIT.
- One sub-module, slot_entry: single-slot storage with write-enable, FSM-update port (status/profile set, profile increment with saturation) and lock input. It is instantiated N times via generate. The read mux and FSM live in the top level.

Test Plan:
1. Reset, then read all 4 slots -> all fields 0, status 0. busy=0, dsp_valid=0, seq_done=0.
2. Slot1: src 0x1000/0x40, dst 0x2000/0x40, status READY. Slot3: READY. Pulse start with dsp_ready=1 and cmp_valid 5 cycles after each handshake:
   - dispatch index 1 with the correct fields, then index 3;
   - slot1 and slot3 profile=5, status DONE;
   - seq_done pulses once; busy falls.
3. Slot0 READY, dsp_ready held 0 for 10 cycles -> dsp_valid and dsp_* stable throughout. Status stays READY and profile is not counted until the handshake.
4. While slot2 is BUSY: write cfg_src_addr=0xDEAD to slot2 and to slot0 -> slot2 unchanged, slot0 updated. Set slot3 READY mid-pass -> slot3 is dispatched in the same pass.
5. Assert reset during WAIT -> next cycle busy=0, dsp_valid=0, all statuses EMPTY, all profiles 0. Later cmp_valid is ignored.
6. No READY slots, start at cycle t -> seq_done high at t+5 only. With PROFILE_WIDTH=4 and a 20-cycle wait, profile saturates at 15.

Source files
------------

// File: rtl/slot_dispatch_pkg.sv
// Shared definitions for the slot dispatch table.
// Holds the 2-bit slot status codes and the sequencer state encoding.
package slot_dispatch_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_e;

endpackage

// File: rtl/slot_dispatch_table_slot_entry.sv
// slot_entry: storage for one DMA descriptor slot.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   lock_i                     host writes are dropped while set (sequencer owns slot)
//   set_*_i / cfg_*_i          per-field host write strobes and data
//   fsm_set_status_i/_status_i sequencer status update (wins over host, never locked)
//   fsm_clr_profile_i          clear busy-cycle counter (dispatch handshake)
//   fsm_inc_profile_i          count one busy cycle, saturating at all-ones
//   *_o                        current slot contents
module slot_entry
   import slot_dispatch_pkg::*;
#(
   parameter int SRC_ADDR_WIDTH = 32,
   parameter int SRC_SIZE_WIDTH = 26,
   parameter int DST_ADDR_WIDTH = 32,
   parameter int DST_SIZE_WIDTH = 26,
   parameter int PROFILE_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      lock_i,
   input  logic                      set_src_addr_i,
   input  logic                      set_src_size_i,
   input  logic                      set_des_addr_i,
   input  logic                      set_des_size_i,
   input  logic                      set_status_i,
   input  logic [SRC_ADDR_WIDTH-1:0] cfg_src_addr_i,
   input  logic [SRC_SIZE_WIDTH-1:0] cfg_src_size_i,
   input  logic [DST_ADDR_WIDTH-1:0] cfg_des_addr_i,
   input  logic [DST_SIZE_WIDTH-1:0] cfg_des_size_i,
   input  logic [1:0]                cfg_status_i,
   input  logic                      fsm_set_status_i,
   input  logic [1:0]                fsm_status_i,
   input  logic                      fsm_clr_profile_i,
   input  logic                      fsm_inc_profile_i,
   output logic [SRC_ADDR_WIDTH-1:0] src_addr_o,
   output logic [SRC_SIZE_WIDTH-1:0] src_size_o,
   output logic [DST_ADDR_WIDTH-1:0] des_addr_o,
   output logic [DST_SIZE_WIDTH-1:0] des_size_o,
   output logic [1:0]                status_o,
   output logic [PROFILE_WIDTH-1:0]  profile_o
);

   logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
   logic [SRC_SIZE_WIDTH-1:0] src_size_q, src_size_d;
   logic [DST_ADDR_WIDTH-1:0] des_addr_q, des_addr_d;
   logic [DST_SIZE_WIDTH-1:0] des_size_q, des_size_d;
   logic [1:0]                status_q,   status_d;
   logic [PROFILE_WIDTH-1:0]  profile_q,  profile_d;

   always_comb begin
      src_addr_d = src_addr_q;
      src_size_d = src_size_q;
      des_addr_d = des_addr_q;
      des_size_d = des_size_q;
      status_d   = status_q;
      profile_d  = profile_q;
      if (!lock_i) begin
         if (set_src_addr_i) src_addr_d = cfg_src_addr_i;
         if (set_src_size_i) src_size_d = cfg_src_size_i;
         if (set_des_addr_i) des_addr_d = cfg_des_addr_i;
         if (set_des_size_i) des_size_d = cfg_des_size_i;
         if (set_status_i)   status_d   = cfg_status_i;
      end
      if (fsm_set_status_i) status_d = fsm_status_i;
      if (fsm_clr_profile_i) begin
         profile_d = '0;
      end else if (fsm_inc_profile_i && (profile_q != {PROFILE_WIDTH{1'b1}})) begin
         profile_d = profile_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_addr_q <= '0;
         src_size_q <= '0;
         des_addr_q <= '0;
         des_size_q <= '0;
         status_q   <= ST_EMPTY;
         profile_q  <= '0;
      end else begin
         src_addr_q <= src_addr_d;
         src_size_q <= src_size_d;
         des_addr_q <= des_addr_d;
         des_size_q <= des_size_d;
         status_q   <= status_d;
         profile_q  <= profile_d;
      end
   end

   assign src_addr_o = src_addr_q;
   assign src_size_o = src_size_q;
   assign des_addr_o = des_addr_q;
   assign des_size_o = des_size_q;
   assign status_o   = status_q;
   assign profile_o  = profile_q;

endmodule

// File: rtl/slot_dispatch_table.sv
// slot_dispatch_table: 2^INDEX_WIDTH descriptor slots plus a dispatch sequencer.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cfg_* / set_*           host config write (slot cfg_index, per-field strobes)
//   rd_index / rd_*         combinational read of one slot, including profile
//   start                   begin one pass over the slots (ignored unless idle)
//   busy, seq_done          sequencer active / one-cycle end-of-pass pulse
//   dsp_valid/dsp_ready     descriptor handshake, dsp_* registered descriptor
//   cmp_valid               completion pulse for the active descriptor
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SCAN  | examine slot ptr, dispatch if READY
// S_ISSUE | descriptor offered, waiting for dsp_ready
// S_WAIT  | descriptor accepted, counting busy cycles until cmp_valid
module slot_dispatch_table
   import slot_dispatch_pkg::*;
#(
   parameter int INDEX_WIDTH    = 2,
   parameter int SRC_ADDR_WIDTH = 32,
   parameter int SRC_SIZE_WIDTH = 26,
   parameter int DST_ADDR_WIDTH = 32,
   parameter int DST_SIZE_WIDTH = 26,
   parameter int PROFILE_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [INDEX_WIDTH-1:0]    cfg_index,
   input  logic [SRC_ADDR_WIDTH-1:0] cfg_src_addr,
   input  logic [SRC_SIZE_WIDTH-1:0] cfg_src_size,
   input  logic [DST_ADDR_WIDTH-1:0] cfg_des_addr,
   input  logic [DST_SIZE_WIDTH-1:0] cfg_des_size,
   input  logic [1:0]                cfg_status,
   input  logic                      set_src_addr,
   input  logic                      set_src_size,
   input  logic                      set_des_addr,
   input  logic                      set_des_size,
   input  logic                      set_status,
   input  logic [INDEX_WIDTH-1:0]    rd_index,
   output logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
   output logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
   output logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
   output logic [DST_SIZE_WIDTH-1:0] rd_des_size,
   output logic [1:0]                rd_status,
   output logic [PROFILE_WIDTH-1:0]  rd_profile,
   input  logic                      start,
   output logic                      busy,
   output logic                      seq_done,
   output logic                      dsp_valid,
   input  logic                      dsp_ready,
   output logic [INDEX_WIDTH-1:0]    dsp_index,
   output logic [SRC_ADDR_WIDTH-1:0] dsp_src_addr,
   output logic [SRC_SIZE_WIDTH-1:0] dsp_src_size,
   output logic [DST_ADDR_WIDTH-1:0] dsp_des_addr,
   output logic [DST_SIZE_WIDTH-1:0] dsp_des_size,
   input  logic                      cmp_valid
);

   localparam int N = 1 << INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] IDX_LAST = {INDEX_WIDTH{1'b1}};

   state_e                    state_q;
   logic [INDEX_WIDTH-1:0]    ptr_q;
   logic                      seq_done_q;
   logic                      dsp_valid_q;
   logic [INDEX_WIDTH-1:0]    dsp_index_q;
   logic [SRC_ADDR_WIDTH-1:0] dsp_src_addr_q;
   logic [SRC_SIZE_WIDTH-1:0] dsp_src_size_q;
   logic [DST_ADDR_WIDTH-1:0] dsp_des_addr_q;
   logic [DST_SIZE_WIDTH-1:0] dsp_des_size_q;

   logic [SRC_ADDR_WIDTH-1:0] src_addr_arr [N];
   logic [SRC_SIZE_WIDTH-1:0] src_size_arr [N];
   logic [DST_ADDR_WIDTH-1:0] des_addr_arr [N];
   logic [DST_SIZE_WIDTH-1:0] des_size_arr [N];
   logic [1:0]                status_arr   [N];
   logic [PROFILE_WIDTH-1:0]  profile_arr  [N];

   // The slot under ptr belongs to the sequencer from offer until completion.
   logic owned;
   logic handshake;
   logic complete;

   assign owned     = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign handshake = (state_q == S_ISSUE) && dsp_ready;
   assign complete  = (state_q == S_WAIT) && cmp_valid;

   for (genvar i = 0; i < N; i++) begin : g_slot
      logic sel_cfg;
      logic sel_ptr;

      assign sel_cfg = (cfg_index == INDEX_WIDTH'(i));
      assign sel_ptr = (ptr_q == INDEX_WIDTH'(i));

      slot_entry #(
         .SRC_ADDR_WIDTH (SRC_ADDR_WIDTH),
         .SRC_SIZE_WIDTH (SRC_SIZE_WIDTH),
         .DST_ADDR_WIDTH (DST_ADDR_WIDTH),
         .DST_SIZE_WIDTH (DST_SIZE_WIDTH),
         .PROFILE_WIDTH  (PROFILE_WIDTH)
      ) u_slot (
         .clk               (clk),
         .reset             (reset),
         .lock_i            (owned && sel_ptr),
         .set_src_addr_i    (set_src_addr && sel_cfg),
         .set_src_size_i    (set_src_size && sel_cfg),
         .set_des_addr_i    (set_des_addr && sel_cfg),
         .set_des_size_i    (set_des_size && sel_cfg),
         .set_status_i      (set_status && sel_cfg),
         .cfg_src_addr_i    (cfg_src_addr),
         .cfg_src_size_i    (cfg_src_size),
         .cfg_des_addr_i    (cfg_des_addr),
         .cfg_des_size_i    (cfg_des_size),
         .cfg_status_i      (cfg_status),
         .fsm_set_status_i  ((handshake || complete) && sel_ptr),
         .fsm_status_i      (handshake ? ST_BUSY : ST_DONE),
         .fsm_clr_profile_i (handshake && sel_ptr),
         .fsm_inc_profile_i ((state_q == S_WAIT) && sel_ptr),
         .src_addr_o        (src_addr_arr[i]),
         .src_size_o        (src_size_arr[i]),
         .des_addr_o        (des_addr_arr[i]),
         .des_size_o        (des_size_arr[i]),
         .status_o          (status_arr[i]),
         .profile_o         (profile_arr[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         ptr_q          <= '0;
         seq_done_q     <= 1'b0;
         dsp_valid_q    <= 1'b0;
         dsp_index_q    <= '0;
         dsp_src_addr_q <= '0;
         dsp_src_size_q <= '0;
         dsp_des_addr_q <= '0;
         dsp_des_size_q <= '0;
      end else begin
         seq_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ptr_q   <= '0;
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (status_arr[ptr_q] == ST_READY) begin
                  dsp_index_q    <= ptr_q;
                  dsp_src_addr_q <= src_addr_arr[ptr_q];
                  dsp_src_size_q <= src_size_arr[ptr_q];
                  dsp_des_addr_q <= des_addr_arr[ptr_q];
                  dsp_des_size_q <= des_size_arr[ptr_q];
                  dsp_valid_q    <= 1'b1;
                  state_q        <= S_ISSUE;
               end else if (ptr_q == IDX_LAST) begin
                  seq_done_q <= 1'b1;
                  state_q    <= S_IDLE;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            S_ISSUE: begin
               if (dsp_ready) begin
                  dsp_valid_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cmp_valid) begin
                  if (ptr_q == IDX_LAST) begin
                     seq_done_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     ptr_q   <= ptr_q + 1'b1;
                     state_q <= S_SCAN;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rd_src_addr = src_addr_arr[rd_index];
   assign rd_src_size = src_size_arr[rd_index];
   assign rd_des_addr = des_addr_arr[rd_index];
   assign rd_des_size = des_size_arr[rd_index];
   assign rd_status   = status_arr[rd_index];
   assign rd_profile  = profile_arr[rd_index];

   assign busy         = (state_q != S_IDLE);
   assign seq_done     = seq_done_q;
   assign dsp_valid    = dsp_valid_q;
   assign dsp_index    = dsp_index_q;
   assign dsp_src_addr = dsp_src_addr_q;
   assign dsp_src_size = dsp_src_size_q;
   assign dsp_des_addr = dsp_des_addr_q;
   assign dsp_des_size = dsp_des_size_q;

endmodule

// File: tb/tb_slot_dispatch_table.sv
// Bench for slot_dispatch_table: directed scenarios plus randomized passes,
// checked against a slot-array model (dispatch order = next READY index).
// A second instance with a 4-bit profile shares all inputs to show saturation.
module tb_slot_dispatch_table;

   localparam int N = 4;
   localparam logic [1:0] EMPTY = 2'd0, READY = 2'd1, BUSY = 2'd2, DONE = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  cfg_index;
   logic [31:0] cfg_src_addr, cfg_des_addr;
   logic [25:0] cfg_src_size, cfg_des_size;
   logic [1:0]  cfg_status;
   logic        set_src_addr, set_src_size, set_des_addr, set_des_size, set_status;
   logic [1:0]  rd_index;
   logic        start, dsp_ready, cmp_valid;

   logic [31:0] rd_src_addr, rd_des_addr, rd_profile, dsp_src_addr, dsp_des_addr;
   logic [25:0] rd_src_size, rd_des_size, dsp_src_size, dsp_des_size;
   logic [1:0]  rd_status, dsp_index;
   logic        busy, seq_done, dsp_valid;

   logic [31:0] b_rd_src_addr, b_rd_des_addr, b_dsp_src_addr, b_dsp_des_addr;
   logic [25:0] b_rd_src_size, b_rd_des_size, b_dsp_src_size, b_dsp_des_size;
   logic [3:0]  b_rd_profile;
   logic [1:0]  b_rd_status, b_dsp_index;
   logic        b_busy, b_seq_done, b_dsp_valid;

   slot_dispatch_table dut (
      .clk(clk), .reset(reset), .cfg_index(cfg_index),
      .cfg_src_addr(cfg_src_addr), .cfg_src_size(cfg_src_size),
      .cfg_des_addr(cfg_des_addr), .cfg_des_size(cfg_des_size), .cfg_status(cfg_status),
      .set_src_addr(set_src_addr), .set_src_size(set_src_size),
      .set_des_addr(set_des_addr), .set_des_size(set_des_size), .set_status(set_status),
      .rd_index(rd_index), .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
      .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size), .rd_status(rd_status),
      .rd_profile(rd_profile), .start(start), .busy(busy), .seq_done(seq_done),
      .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_index(dsp_index),
      .dsp_src_addr(dsp_src_addr), .dsp_src_size(dsp_src_size),
      .dsp_des_addr(dsp_des_addr), .dsp_des_size(dsp_des_size), .cmp_valid(cmp_valid)
   );

   slot_dispatch_table #(.PROFILE_WIDTH(4)) dut_p4 (
      .clk(clk), .reset(reset), .cfg_index(cfg_index),
      .cfg_src_addr(cfg_src_addr), .cfg_src_size(cfg_src_size),
      .cfg_des_addr(cfg_des_addr), .cfg_des_size(cfg_des_size), .cfg_status(cfg_status),
      .set_src_addr(set_src_addr), .set_src_size(set_src_size),
      .set_des_addr(set_des_addr), .set_des_size(set_des_size), .set_status(set_status),
      .rd_index(rd_index), .rd_src_addr(b_rd_src_addr), .rd_src_size(b_rd_src_size),
      .rd_des_addr(b_rd_des_addr), .rd_des_size(b_rd_des_size), .rd_status(b_rd_status),
      .rd_profile(b_rd_profile), .start(start), .busy(b_busy), .seq_done(b_seq_done),
      .dsp_valid(b_dsp_valid), .dsp_ready(dsp_ready), .dsp_index(b_dsp_index),
      .dsp_src_addr(b_dsp_src_addr), .dsp_src_size(b_dsp_src_size),
      .dsp_des_addr(b_dsp_des_addr), .dsp_des_size(b_dsp_des_size), .cmp_valid(cmp_valid)
   );

   // reference model of the slot table
   logic [31:0] m_src [N];
   logic [25:0] m_ssz [N];
   logic [31:0] m_dst [N];
   logic [25:0] m_dsz [N];
   logic [1:0]  m_st  [N];
   int unsigned m_prof[N];

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_src[i] = '0; m_ssz[i] = '0; m_dst[i] = '0; m_dsz[i] = '0;
         m_st[i] = EMPTY; m_prof[i] = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_clear();
   endtask

   // mask bit order: 0 src_addr, 1 src_size, 2 des_addr, 3 des_size, 4 status
   task automatic drive_wr(input int idx, input logic [4:0] mask, input logic [31:0] sa,
                           input logic [25:0] ss, input logic [31:0] da,
                           input logic [25:0] ds, input logic [1:0] st);
      cfg_index = 2'(idx);
      cfg_src_addr = sa; cfg_src_size = ss; cfg_des_addr = da; cfg_des_size = ds;
      cfg_status = st;
      {set_status, set_des_size, set_des_addr, set_src_size, set_src_addr} = mask;
   endtask

   task automatic model_wr(input int idx, input logic [4:0] mask, input logic [31:0] sa,
                           input logic [25:0] ss, input logic [31:0] da,
                           input logic [25:0] ds, input logic [1:0] st);
      if (mask[0]) m_src[idx] = sa;
      if (mask[1]) m_ssz[idx] = ss;
      if (mask[2]) m_dst[idx] = da;
      if (mask[3]) m_dsz[idx] = ds;
      if (mask[4]) m_st[idx]  = st;
   endtask

   task automatic clr_wr();
      {set_status, set_des_size, set_des_addr, set_src_size, set_src_addr} = 5'b0;
   endtask

   task automatic write_slot(input int idx, input logic [4:0] mask, input logic [31:0] sa,
                             input logic [25:0] ss, input logic [31:0] da,
                             input logic [25:0] ds, input logic [1:0] st);
      drive_wr(idx, mask, sa, ss, da, ds, st);
      tick();
      clr_wr();
      model_wr(idx, mask, sa, ss, da, ds, st);
   endtask

   task automatic check_slots(input string tag);
      int unsigned sat;
      for (int i = 0; i < N; i++) begin
         rd_index = 2'(i);
         #1;
         sat = (m_prof[i] > 15) ? 15 : m_prof[i];
         check($sformatf("%s_src%0d", tag, i), rd_src_addr, m_src[i]);
         check($sformatf("%s_ssz%0d", tag, i), rd_src_size, m_ssz[i]);
         check($sformatf("%s_dst%0d", tag, i), rd_des_addr, m_dst[i]);
         check($sformatf("%s_dsz%0d", tag, i), rd_des_size, m_dsz[i]);
         check($sformatf("%s_st%0d", tag, i), rd_status, m_st[i]);
         check($sformatf("%s_prof%0d", tag, i), rd_profile, m_prof[i]);
         check($sformatf("%s_prof4_%0d", tag, i), b_rd_profile, sat);
      end
   endtask

   function automatic int next_ready(input int from);
      for (int i = from; i < N; i++)
         if (m_st[i] == READY) return i;
      return -1;
   endfunction

   task automatic wait_valid(output bit ok, inout int cyc);
      int n = 0;
      while (!dsp_valid && n < 20) begin
         tick();
         cyc++;
         n++;
      end
      check("dsp_valid_rise", dsp_valid, 1'b1);
      ok = dsp_valid;
   endtask

   // One full pass; expected order is recomputed from the model after each
   // completion so host writes made mid-pass are honoured.
   task automatic run_pass(input string tag, input int rdy_min, input int rdy_max,
                           input int cmp_min, input int cmp_max, input bit mid_wr);
      int cur, cyc, d, c, n, widx;
      bit ok, first;
      logic [4:0]  wm;
      logic [31:0] wsa, wda;
      logic [25:0] wss, wds;
      logic [1:0]  wst;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      check({tag, "_busy"}, busy, 1'b1);
      cur = next_ready(0);
      first = 1'b1;
      while (cur >= 0) begin
         wait_valid(ok, cyc);
         if (!ok) begin
            do_reset();
            return;
         end
         if (first) check({tag, "_latency"}, cyc, cur + 2);
         first = 1'b0;
         check({tag, "_idx"}, dsp_index, cur);
         check({tag, "_dsrc"}, dsp_src_addr, m_src[cur]);
         check({tag, "_dssz"}, dsp_src_size, m_ssz[cur]);
         check({tag, "_ddst"}, dsp_des_addr, m_dst[cur]);
         check({tag, "_ddsz"}, dsp_des_size, m_dsz[cur]);
         d = $urandom_range(rdy_max, rdy_min);
         rd_index = 2'(cur);
         for (int k = 0; k < d; k++) begin
            tick();
            check({tag, "_hold_valid"}, dsp_valid, 1'b1);
            check({tag, "_hold_idx"}, dsp_index, cur);
            check({tag, "_hold_src"}, dsp_src_addr, m_src[cur]);
            check({tag, "_hold_dsz"}, dsp_des_size, m_dsz[cur]);
            check({tag, "_hold_st"}, rd_status, READY);
            check({tag, "_hold_prof"}, rd_profile, m_prof[cur]);
         end
         dsp_ready = 1'b1;
         tick();
         dsp_ready = 1'b0;
         m_st[cur] = BUSY;
         m_prof[cur] = 0;
         check({tag, "_valid_drop"}, dsp_valid, 1'b0);
         check({tag, "_st_busy"}, rd_status, BUSY);
         c = $urandom_range(cmp_max, cmp_min);
         for (int k = 1; k <= c; k++) begin
            widx = -1;
            if (mid_wr && $urandom_range(2, 0) == 0) begin
               widx = $urandom_range(N - 1, 0);
               wm = 5'($urandom);
               wsa = $urandom; wda = $urandom;
               wss = 26'($urandom); wds = 26'($urandom);
               wst = ($urandom_range(1, 0) == 1) ? READY : 2'($urandom);
               drive_wr(widx, wm, wsa, wss, wda, wds, wst);
            end
            cmp_valid = (k == c);
            tick();
            cmp_valid = 1'b0;
            clr_wr();
            if (widx >= 0 && widx != cur) model_wr(widx, wm, wsa, wss, wda, wds, wst);
            cyc++;
         end
         m_prof[cur] = c;
         m_st[cur] = DONE;
         cur = next_ready(cur + 1);
      end
      n = 0;
      while (!seq_done && n < 20) begin
         tick();
         cyc++;
         n++;
      end
      check({tag, "_seq_done"}, seq_done, 1'b1);
      check({tag, "_seq_done_p4"}, b_seq_done, 1'b1);
      if (first) check({tag, "_empty_latency"}, cyc, N + 1);
      tick();
      check({tag, "_seq_done_pulse"}, seq_done, 1'b0);
      check({tag, "_busy_fall"}, busy, 1'b0);
      check_slots(tag);
   endtask

   initial begin
      bit ok;
      int cyc;
      reset = 1'b1; start = 1'b0; dsp_ready = 1'b0; cmp_valid = 1'b0; rd_index = '0;
      drive_wr(0, 5'b0, '0, '0, '0, '0, '0);
      do_reset();

      // 1: reset state
      check("rst_busy", busy, 1'b0);
      check("rst_dsp_valid", dsp_valid, 1'b0);
      check("rst_seq_done", seq_done, 1'b0);
      check("rst_dsp_index", dsp_index, 0);
      check("rst_dsp_src", dsp_src_addr, 0);
      check("rst_dsp_dsz", dsp_des_size, 0);
      check_slots("rst");

      // 2: slots 1 and 3 dispatched in order, profile 5
      write_slot(1, 5'b11111, 32'h1000, 26'h40, 32'h2000, 26'h40, READY);
      write_slot(3, 5'b11111, 32'h3000, 26'h80, 32'h4000, 26'h10, READY);
      run_pass("p2", 0, 0, 5, 5, 1'b0);

      // 3: backpressure on slot 0 for 10 cycles
      write_slot(0, 5'b11111, 32'hA5A5_0000, 26'h123, 32'h5A5A_0000, 26'h321, READY);
      run_pass("p3", 10, 10, 1, 3, 1'b0);

      // 4: writes during WAIT of slot 2; slot 3 becomes READY mid-pass
      do_reset();
      write_slot(2, 5'b11111, 32'h2222, 26'h22, 32'h3333, 26'h33, READY);
      start = 1'b1; tick(); start = 1'b0;
      cyc = 1;
      wait_valid(ok, cyc);
      check("p4_idx2", dsp_index, 2);
      dsp_ready = 1'b1; tick(); dsp_ready = 1'b0;
      m_st[2] = BUSY;
      drive_wr(2, 5'b00001, 32'hDEAD, '0, '0, '0, '0); tick(); clr_wr();
      drive_wr(0, 5'b00001, 32'hDEAD, '0, '0, '0, '0); tick(); clr_wr();
      model_wr(0, 5'b00001, 32'hDEAD, '0, '0, '0, '0);
      drive_wr(3, 5'b10000, '0, '0, '0, '0, READY); tick(); clr_wr();
      model_wr(3, 5'b10000, '0, '0, '0, '0, READY);
      rd_index = 2'd2; #1;
      check("p4_locked_src", rd_src_addr, 32'h2222);
      check("p4_locked_st", rd_status, BUSY);
      rd_index = 2'd0; #1;
      check("p4_open_src", rd_src_addr, 32'hDEAD);
      cmp_valid = 1'b1; tick(); cmp_valid = 1'b0;
      m_st[2] = DONE; m_prof[2] = 4;
      wait_valid(ok, cyc);
      check("p4_idx3", dsp_index, 3);
      dsp_ready = 1'b1; tick(); dsp_ready = 1'b0;
      cmp_valid = 1'b1; tick(); cmp_valid = 1'b0;
      m_st[3] = DONE; m_prof[3] = 1;
      check("p4_seq_done", seq_done, 1'b1);
      tick();
      check_slots("p4");

      // 5: reset while waiting for completion
      write_slot(1, 5'b11111, 32'h77, 26'h7, 32'h88, 26'h8, READY);
      start = 1'b1; tick(); start = 1'b0;
      cyc = 1;
      wait_valid(ok, cyc);
      dsp_ready = 1'b1; tick(); dsp_ready = 1'b0;
      tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      model_clear();
      check("p5_busy", busy, 1'b0);
      check("p5_valid", dsp_valid, 1'b0);
      check("p5_dsp_idx", dsp_index, 0);
      check("p5_dsp_src", dsp_src_addr, 0);
      check_slots("p5a");
      cmp_valid = 1'b1; tick(); cmp_valid = 1'b0;
      check("p5_cmp_ignored", busy, 1'b0);
      check_slots("p5b");

      // 6: empty-table pass latency, then profile saturation on the 4-bit copy
      run_pass("p6a", 0, 0, 1, 1, 1'b0);
      write_slot(2, 5'b10000, '0, '0, '0, '0, READY);
      run_pass("p6b", 0, 2, 20, 20, 1'b0);

      // randomized passes with host traffic during completion waits
      for (int it = 0; it < 30; it++) begin
         for (int s = 0; s < N; s++) begin
            if ($urandom_range(1, 0) == 1)
               write_slot(s, 5'($urandom) | 5'b10000, $urandom, 26'($urandom), $urandom,
                          26'($urandom), ($urandom_range(2, 0) != 0) ? READY : 2'($urandom));
         end
         run_pass($sformatf("r%0d", it), 0, 3, 1, (it % 6 == 5) ? 20 : 6, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
